// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/return sequencer: privilege encodings,
// request kinds, FSM states, cause codes and mstatus bit positions.
package trap_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        REQ_EXC  = 2'd0,
        REQ_INT  = 2'd1,
        REQ_MRET = 2'd2,
        REQ_SRET = 2'd3
    } req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [4:0] CAUSE_ILLEGAL_INST = 5'd2;

    localparam int MSTATUS_SIE    = 1;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_SPIE   = 5;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_SPP    = 8;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_target_calc.sv
// Combinational trap resolution: illegal-return demotion, M/S delegation, new status
// fields, epc/cause values and redirect target. VECTORED_TVEC_EN enables vectored interrupts.
module trap_target_calc
    import trap_pkg::*;
(
    input  req_type_e   req_type_i,
    input  logic [4:0]  req_cause_i,
    input  logic [31:0] req_pc_i,
    input  logic [1:0]  priv_i,
    input  logic [63:0] mstatus_i,
    input  logic [63:0] medeleg_i,
    input  logic [31:0] mideleg_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] stvec_i,
    input  logic [31:0] sepc_i,
    input  logic [31:0] scause_i,
    output logic [6:0]  mstatus_set_o,
    output logic [31:0] mepc_set_o,
    output logic [31:0] mcause_set_o,
    output logic [31:0] sepc_set_o,
    output logic [31:0] scause_set_o,
    output logic [1:0]  new_priv_o,
    output logic [31:0] target_pc_o
);

    req_type_e   eff_type;
    logic [4:0]  eff_cause;
    logic        is_int;
    logic        to_s;
    logic [31:0] tvec;
    logic [31:0] vec_off;
    logic [31:0] trap_cause;
    logic [1:0]  mpp;
    logic        mpie, mie, spp, spie, sie;

    always_comb begin
        eff_type  = req_type_i;
        eff_cause = req_cause_i;
        // A return the current privilege may not execute is reported as an illegal instruction.
        if ((req_type_i == REQ_MRET && priv_i != PRIV_M) ||
            (req_type_i == REQ_SRET && priv_i == PRIV_U)) begin
            eff_type  = REQ_EXC;
            eff_cause = CAUSE_ILLEGAL_INST;
        end
        is_int     = (eff_type == REQ_INT);
        to_s       = (priv_i != PRIV_M) &&
                     (is_int ? mideleg_i[eff_cause] : medeleg_i[{1'b0, eff_cause}]);
        trap_cause = {is_int, 26'b0, eff_cause};

        mpp  = mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        mpie = mstatus_i[MSTATUS_MPIE];
        mie  = mstatus_i[MSTATUS_MIE];
        spp  = mstatus_i[MSTATUS_SPP];
        spie = mstatus_i[MSTATUS_SPIE];
        sie  = mstatus_i[MSTATUS_SIE];

        mepc_set_o   = mepc_i;
        mcause_set_o = mcause_i;
        sepc_set_o   = sepc_i;
        scause_set_o = scause_i;
        new_priv_o   = priv_i;
        tvec         = mtvec_i;
        vec_off      = 32'd0;
        target_pc_o  = 32'd0;

        case (eff_type)
            REQ_MRET: begin
                new_priv_o  = mpp;
                mie         = mstatus_i[MSTATUS_MPIE];
                mpie        = 1'b1;
                mpp         = PRIV_U;
                target_pc_o = mepc_i;
            end
            REQ_SRET: begin
                new_priv_o  = {1'b0, spp};
                sie         = mstatus_i[MSTATUS_SPIE];
                spie        = 1'b1;
                spp         = 1'b0;
                target_pc_o = sepc_i;
            end
            default: begin
                if (to_s) begin
                    sepc_set_o   = align_word(req_pc_i);
                    scause_set_o = trap_cause;
                    spp          = priv_i[0];
                    spie         = mstatus_i[MSTATUS_SIE];
                    sie          = 1'b0;
                    new_priv_o   = PRIV_S;
                    tvec         = stvec_i;
                end else begin
                    mepc_set_o   = align_word(req_pc_i);
                    mcause_set_o = trap_cause;
                    mpp          = priv_i;
                    mpie         = mstatus_i[MSTATUS_MIE];
                    mie          = 1'b0;
                    new_priv_o   = PRIV_M;
                    tvec         = mtvec_i;
                end
`ifdef VECTORED_TVEC_EN
                if (is_int && tvec[1:0] == 2'b01) begin
                    vec_off = {25'b0, eff_cause, 2'b00};
                end
`endif
                target_pc_o = align_word(tvec) + vec_off;
            end
        endcase

        mstatus_set_o = {mpp, mpie, mie, spp, spie, sie};
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: IDLE -> COMMIT (CSR trap-set strobe) -> REDIRECT (PC handshake).
// Owns the privilege register. Optional build macro: VECTORED_TVEC_EN.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        reqValid_i,
    output logic        reqReady_o,
    input  logic [1:0]  reqType_i,
    input  logic [4:0]  reqCause_i,
    input  logic [31:0] reqPc_i,
    input  logic [63:0] csrMStatus_i,
    input  logic [63:0] csrMedeleg_i,
    input  logic [31:0] csrMideleg_i,
    input  logic [31:0] csrMtvec_i,
    input  logic [31:0] csrMepc_i,
    input  logic [31:0] csrMCause_i,
    input  logic [31:0] csrStvec_i,
    input  logic [31:0] csrSepc_i,
    input  logic [31:0] csrSCause_i,
    output logic [6:0]  csrMStatusSet_o,
    output logic [31:0] csrMepcSet_o,
    output logic [31:0] csrMCauseSet_o,
    output logic [31:0] csrSepcSet_o,
    output logic [31:0] csrSCauseSet_o,
    output logic        csrTrapSetEn_o,
    output logic        redirValid_o,
    input  logic        redirReady_i,
    output logic [31:0] redirPc_o,
    output logic [1:0]  privMode_o
);

    state_e      state_q, state_d;
    logic [1:0]  priv_q, priv_d;
    req_type_e   req_type_q, req_type_d;
    logic [4:0]  req_cause_q, req_cause_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic [6:0]  calc_mstatus;
    logic [31:0] calc_mepc, calc_mcause, calc_sepc, calc_scause, calc_target;
    logic [1:0]  calc_priv;
    logic        accept;

    trap_target_calc u_calc (
        .req_type_i    (req_type_q),
        .req_cause_i   (req_cause_q),
        .req_pc_i      (req_pc_q),
        .priv_i        (priv_q),
        .mstatus_i     (csrMStatus_i),
        .medeleg_i     (csrMedeleg_i),
        .mideleg_i     (csrMideleg_i),
        .mtvec_i       (csrMtvec_i),
        .mepc_i        (csrMepc_i),
        .mcause_i      (csrMCause_i),
        .stvec_i       (csrStvec_i),
        .sepc_i        (csrSepc_i),
        .scause_i      (csrSCause_i),
        .mstatus_set_o (calc_mstatus),
        .mepc_set_o    (calc_mepc),
        .mcause_set_o  (calc_mcause),
        .sepc_set_o    (calc_sepc),
        .scause_set_o  (calc_scause),
        .new_priv_o    (calc_priv),
        .target_pc_o   (calc_target)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            priv_q      <= RESET_PRIV;
            req_type_q  <= REQ_EXC;
            req_cause_q <= 5'd0;
            req_pc_q    <= 32'd0;
            redir_pc_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            priv_q      <= priv_d;
            req_type_q  <= req_type_d;
            req_cause_q <= req_cause_d;
            req_pc_q    <= req_pc_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign accept = (state_q == ST_IDLE) && reqValid_i;

    always_comb begin
        state_d     = state_q;
        priv_d      = priv_q;
        req_type_d  = req_type_q;
        req_cause_d = req_cause_q;
        req_pc_d    = req_pc_q;
        redir_pc_d  = redir_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_type_d  = req_type_e'(reqType_i);
                    req_cause_d = reqCause_i;
                    req_pc_d    = reqPc_i;
                    state_d     = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                // Target is captured here so redirPc_o stays stable even if CSR inputs move.
                priv_d     = calc_priv;
                redir_pc_d = calc_target;
                state_d    = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                if (redirReady_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        reqReady_o      = (state_q == ST_IDLE);
        csrTrapSetEn_o  = (state_q == ST_COMMIT);
        redirValid_o    = (state_q == ST_REDIRECT);
        redirPc_o       = redir_pc_q;
        privMode_o      = priv_q;
        csrMStatusSet_o = 7'd0;
        csrMepcSet_o    = 32'd0;
        csrMCauseSet_o  = 32'd0;
        csrSepcSet_o    = 32'd0;
        csrSCauseSet_o  = 32'd0;
        if (state_q == ST_COMMIT) begin
            csrMStatusSet_o = calc_mstatus;
            csrMepcSet_o    = calc_mepc;
            csrMCauseSet_o  = calc_mcause;
            csrSepcSet_o    = calc_sepc;
            csrSCauseSet_o  = calc_scause;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: traps, delegation, returns, illegal
// returns, vectored target, redirect back-pressure and reset during redirect.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        reqValid_i;
    logic        reqReady_o;
    logic [1:0]  reqType_i;
    logic [4:0]  reqCause_i;
    logic [31:0] reqPc_i;
    logic [63:0] csrMStatus_i;
    logic [63:0] csrMedeleg_i;
    logic [31:0] csrMideleg_i;
    logic [31:0] csrMtvec_i;
    logic [31:0] csrMepc_i;
    logic [31:0] csrMCause_i;
    logic [31:0] csrStvec_i;
    logic [31:0] csrSepc_i;
    logic [31:0] csrSCause_i;
    logic [6:0]  csrMStatusSet_o;
    logic [31:0] csrMepcSet_o;
    logic [31:0] csrMCauseSet_o;
    logic [31:0] csrSepcSet_o;
    logic [31:0] csrSCauseSet_o;
    logic        csrTrapSetEn_o;
    logic        redirValid_o;
    logic        redirReady_i;
    logic [31:0] redirPc_o;
    logic [1:0]  privMode_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] vec_exp;

    always #5 clk = ~clk;

    trap_ctrl #(.RESET_PRIV(2'b11)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .reqValid_i      (reqValid_i),
        .reqReady_o      (reqReady_o),
        .reqType_i       (reqType_i),
        .reqCause_i      (reqCause_i),
        .reqPc_i         (reqPc_i),
        .csrMStatus_i    (csrMStatus_i),
        .csrMedeleg_i    (csrMedeleg_i),
        .csrMideleg_i    (csrMideleg_i),
        .csrMtvec_i      (csrMtvec_i),
        .csrMepc_i       (csrMepc_i),
        .csrMCause_i     (csrMCause_i),
        .csrStvec_i      (csrStvec_i),
        .csrSepc_i       (csrSepc_i),
        .csrSCause_i     (csrSCause_i),
        .csrMStatusSet_o (csrMStatusSet_o),
        .csrMepcSet_o    (csrMepcSet_o),
        .csrMCauseSet_o  (csrMCauseSet_o),
        .csrSepcSet_o    (csrSepcSet_o),
        .csrSCauseSet_o  (csrSCauseSet_o),
        .csrTrapSetEn_o  (csrTrapSetEn_o),
        .redirValid_o    (redirValid_o),
        .redirReady_i    (redirReady_i),
        .redirPc_o       (redirPc_o),
        .privMode_o      (privMode_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns #1 into the COMMIT cycle.
    task automatic issue(input logic [1:0] t, input logic [4:0] c, input logic [31:0] pc);
        reqValid_i = 1'b1;
        reqType_i  = t;
        reqCause_i = c;
        reqPc_i    = pc;
        step();
        reqValid_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b0;
        reqValid_i   = 1'b0;
        reqType_i    = 2'd0;
        reqCause_i   = 5'd0;
        reqPc_i      = 32'd0;
        csrMStatus_i = 64'd0;
        csrMedeleg_i = 64'd0;
        csrMideleg_i = 32'd0;
        csrMtvec_i   = 32'd0;
        csrMepc_i    = 32'd0;
        csrMCause_i  = 32'd0;
        csrStvec_i   = 32'd0;
        csrSepc_i    = 32'd0;
        csrSCause_i  = 32'd0;
        redirReady_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", reqReady_o, 1);
        chk("rst_strobe", csrTrapSetEn_o, 0);
        chk("rst_redir_valid", redirValid_o, 0);
        chk("rst_redir_pc", redirPc_o, 0);
        chk("rst_priv", privMode_o, 2'b11);
        chk("rst_mstatus_set", csrMStatusSet_o, 0);
        @(negedge clk);
        reset_i = 1'b1;
        step();

        // M-mode exception 11
        csrMStatus_i = 64'h8;
        csrMtvec_i   = 32'h8000_0000;
        csrSepc_i    = 32'h5550;
        csrSCause_i  = 32'h33;
        issue(2'd0, 5'd11, 32'h100);
        chk("a_strobe", csrTrapSetEn_o, 1);
        chk("a_ready_busy", reqReady_o, 0);
        chk("a_redir_early", redirValid_o, 0);
        chk("a_mepc", csrMepcSet_o, 32'h100);
        chk("a_mcause", csrMCauseSet_o, 32'hB);
        chk("a_mstatus", csrMStatusSet_o, 7'h70);
        chk("a_sepc_pass", csrSepcSet_o, 32'h5550);
        chk("a_scause_pass", csrSCauseSet_o, 32'h33);
        step();
        chk("a_strobe_off", csrTrapSetEn_o, 0);
        chk("a_redir_valid", redirValid_o, 1);
        chk("a_redir_pc", redirPc_o, 32'h8000_0000);
        chk("a_priv", privMode_o, 2'b11);
        step();
        chk("a_idle_redir", redirValid_o, 0);
        chk("a_idle_ready", reqReady_o, 1);

        // MRET to U
        csrMStatus_i = 64'h80;
        csrMepc_i    = 32'h400;
        csrMCause_i  = 32'hB;
        issue(2'd2, 5'd0, 32'h0);
        chk("b_strobe", csrTrapSetEn_o, 1);
        chk("b_mstatus", csrMStatusSet_o, 7'h18);
        chk("b_mepc_pass", csrMepcSet_o, 32'h400);
        chk("b_mcause_pass", csrMCauseSet_o, 32'hB);
        step();
        chk("b_redir_pc", redirPc_o, 32'h400);
        chk("b_priv", privMode_o, 2'b00);
        step();

        // U-mode exception 8 delegated to S
        csrMStatus_i = 64'h2;
        csrMedeleg_i = 64'h100;
        csrStvec_i   = 32'h3000;
        issue(2'd0, 5'd8, 32'h2004);
        chk("c_sepc", csrSepcSet_o, 32'h2004);
        chk("c_scause", csrSCauseSet_o, 32'h8);
        chk("c_mepc_pass", csrMepcSet_o, 32'h400);
        chk("c_mcause_pass", csrMCauseSet_o, 32'hB);
        chk("c_mstatus", csrMStatusSet_o, 7'h02);
        step();
        chk("c_redir_pc", redirPc_o, 32'h3000);
        chk("c_priv", privMode_o, 2'b01);
        step();

        // SRET from S with SPP=0
        csrMStatus_i = 64'h20;
        csrSepc_i    = 32'h2004;
        issue(2'd3, 5'd0, 32'h0);
        chk("d_mstatus", csrMStatusSet_o, 7'h03);
        step();
        chk("d_redir_pc", redirPc_o, 32'h2004);
        chk("d_priv", privMode_o, 2'b00);
        step();

        // SRET from U is illegal -> M trap cause 2
        csrMStatus_i = 64'h0;
        csrMedeleg_i = 64'h0;
        csrSCause_i  = 32'h8;
        issue(2'd3, 5'd0, 32'h2007);
        chk("e_mcause", csrMCauseSet_o, 32'h2);
        chk("e_mepc", csrMepcSet_o, 32'h2004);
        chk("e_mstatus", csrMStatusSet_o, 7'h00);
        chk("e_scause_pass", csrSCauseSet_o, 32'h8);
        step();
        chk("e_redir_pc", redirPc_o, 32'h8000_0000);
        chk("e_priv", privMode_o, 2'b11);
        step();

        // Interrupt 7 with mode-01 mtvec, redirect held off 5 cycles
`ifdef VECTORED_TVEC_EN
        vec_exp = 32'h101C;
`else
        vec_exp = 32'h1000;
`endif
        csrMStatus_i = 64'h8;
        csrMtvec_i   = 32'h1001;
        csrMideleg_i = 32'hFFFF_FFFF;
        redirReady_i = 1'b0;
        issue(2'd1, 5'd7, 32'h500);
        chk("f_mcause", csrMCauseSet_o, 32'h8000_0007);
        chk("f_mepc", csrMepcSet_o, 32'h500);
        chk("f_mstatus", csrMStatusSet_o, 7'h70);
        step();
        chk("f_redir_valid", redirValid_o, 1);
        chk("f_redir_pc", redirPc_o, vec_exp);
        reqValid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("f_hold_valid", redirValid_o, 1);
            chk("f_hold_pc", redirPc_o, vec_exp);
            chk("f_hold_ready", reqReady_o, 0);
            chk("f_hold_strobe", csrTrapSetEn_o, 0);
        end
        redirReady_i = 1'b1;
        reqValid_i   = 1'b0;
        step();
        chk("f_done_valid", redirValid_o, 0);
        chk("f_done_ready", reqReady_o, 1);
        chk("f_done_strobe", csrTrapSetEn_o, 0);

        // Exception with same mtvec always uses base
        issue(2'd0, 5'd3, 32'h600);
        chk("g_mcause", csrMCauseSet_o, 32'h3);
        step();
        chk("g_redir_pc", redirPc_o, 32'h1000);
        step();

        // Reset asserted during REDIRECT after MRET to U
        csrMStatus_i = 64'h0;
        csrMepc_i    = 32'h700;
        redirReady_i = 1'b0;
        issue(2'd2, 5'd0, 32'h0);
        step();
        chk("h_priv_u", privMode_o, 2'b00);
        chk("h_redir_valid", redirValid_o, 1);
        reset_i = 1'b0;
        #1;
        chk("h_rst_ready", reqReady_o, 1);
        chk("h_rst_redir", redirValid_o, 0);
        chk("h_rst_priv", privMode_o, 2'b11);
        chk("h_rst_strobe", csrTrapSetEn_o, 0);
        chk("h_rst_pc", redirPc_o, 0);
        @(negedge clk);
        reset_i = 1'b1;
        step();
        chk("h_after_redir", redirValid_o, 0);
        chk("h_after_ready", reqReady_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
